// File: rtl/fmap_writer.sv
// rtl/fmap_writer.sv - output feature-map write-back: scan-order addressing, one pending write register.
// Optional ReLU on stored data when FMAP_RELU_EN is defined.
module fmap_writer #(
  parameter int OUT_WIDTH  = 222,
  parameter int OUT_HEIGHT = 222,
  parameter int KERNEL_NUM = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int KW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
  localparam int CW = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;
  localparam int RW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam logic [ADDR_WIDTH-1:0] PLANE_SZ = ADDR_WIDTH'(OUT_WIDTH * OUT_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_SZ   = ADDR_WIDTH'(OUT_WIDTH);
  localparam logic [KW-1:0] K_MAX   = KW'(KERNEL_NUM - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(OUT_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(OUT_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [ADDR_WIDTH-1:0] k_base_q, k_base_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

  logic                  accept;
  logic                  last_pos;
  logic [DATA_WIDTH-1:0] load_data;

  assign accept   = in_valid && in_ready;
  assign last_pos = (k_q == K_MAX) && (col_q == COL_MAX) && (row_q == ROW_MAX);

`ifdef FMAP_RELU_EN
  assign load_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign load_data = in_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      k_base_q   <= '0;
      row_base_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      col_q      <= col_d;
      row_q      <= row_d;
      k_base_q   <= k_base_d;
      row_base_q <= row_base_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_pos) state_d = DRAIN;
      DRAIN:   if (mem_we_q && mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Running bases k*W*H and row*W replace multipliers in the address path.
  always_comb begin
    k_d        = k_q;
    col_d      = col_q;
    row_d      = row_q;
    k_base_d   = k_base_q;
    row_base_d = row_base_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (state_q == IDLE && start) begin
      k_d        = '0;
      col_d      = '0;
      row_d      = '0;
      k_base_d   = '0;
      row_base_d = '0;
    end
    if (accept) begin
      mem_we_d   = 1'b1;
      mem_addr_d = k_base_q + row_base_q + ADDR_WIDTH'(col_q);
      mem_data_d = load_data;
      if (k_q != K_MAX) begin
        k_d      = k_q + 1'b1;
        k_base_d = k_base_q + PLANE_SZ;
      end else begin
        k_d      = '0;
        k_base_d = '0;
        if (col_q != COL_MAX) begin
          col_d = col_q + 1'b1;
        end else begin
          col_d = '0;
          if (row_q != ROW_MAX) begin
            row_d      = row_q + 1'b1;
            row_base_d = row_base_q + ROW_SZ;
          end else begin
            row_d      = '0;
            row_base_d = '0;
          end
        end
      end
    end else if (mem_we_q && mem_ready) begin
      mem_we_d = 1'b0;
    end
  end

  always_comb begin
    in_ready   = (state_q == RUN) && (!mem_we_q || mem_ready);
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_data   = mem_data_q;
  end

endmodule

// File: doc/fmap_writer.md
Name: fmap_writer

Overview:
- Write-back end of the convolution datapath: accepts the stream of per-window convolution results and stores each one into the output feature-map memory at its (kernel, row, col) position.
- Counts positions in the same scan order the window selector uses to produce windows: kernel index innermost, then column, then row.
- Sits between the MAC/accumulator array and the output feature-map RAM; one start-to-frame_done run writes one complete output frame.

Parameters:
- OUT_WIDTH, 222, output columns (224 - 3 + 1).
- OUT_HEIGHT, 222, output rows.
- KERNEL_NUM, 64, output channels; one result per kernel per window position.
- DATA_WIDTH, 32, result width (two's complement).
- ADDR_WIDTH, 22, memory word-address width; must satisfy OUT_WIDTH*OUT_HEIGHT*KERNEL_NUM <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- in_valid  in  1  in_data is valid.
- in_data  in  DATA_WIDTH  convolution result for the current position.
- in_ready  out  1  writer accepts in_data this cycle.
- mem_we  out  1  write request pending.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_data  out  DATA_WIDTH  write data.
- mem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Reset (async, active-high): state=IDLE; counters k, col, row = 0; mem_we=0, mem_addr=0, mem_data=0, busy=0, frame_done=0, in_ready=0.
- States:
  - IDLE: in_ready=0. start moves to RUN and clears counters.
  - RUN: accepts inputs.
  - DRAIN: waits for the final write to be accepted.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE.
- Output register holds one pending write.
  - In RUN: in_ready = !mem_we || mem_ready.
  - Accept = in_valid && in_ready. On accept, next cycle: mem_we=1, mem_addr = k*OUT_WIDTH*OUT_HEIGHT + row*OUT_WIDTH + col, mem_data=in_data.
  - Latency from accept to mem_we is one cycle.
  - mem_we && mem_ready with no new accept: mem_we clears to 0 next cycle.
  - Pending write held stable (addr and data) while mem_ready=0.
- Address arithmetic: computed in ADDR_WIDTH-bit unsigned; an incremental running base per counter is permitted. Results must equal the formula above, with no truncation for legal parameters.
- Counter advance on each accept:
  - k increments until k==KERNEL_NUM-1, then wraps to 0 and col increments.
  - col==OUT_WIDTH-1 wraps to 0 and row increments.
  - Accept of the final position (k, col, row all at max) moves RUN to DRAIN; in_ready=0 from then on.
- DRAIN leaves for DONE in the cycle after the final write has mem_we && mem_ready.
- Simultaneous start while busy: ignored, no restart.
- start and in_valid in the same IDLE cycle: in_valid is not accepted; the first accept can occur in the next cycle.
- in_valid in IDLE: ignored, no write, no counter change.
- Back-to-back throughput: one result per cycle while mem_ready=1.
- Reset mid-frame: all state and counters cleared immediately. Any pending write is discarded and mem_we drops asynchronously. frame_done is not asserted.

Optional Feature:
- Macro FMAP_RELU_EN.
- Defined: the stored value is ReLU(in_data). If in_data[DATA_WIDTH-1]==1, mem_data=0; otherwise mem_data=in_data. Applied at register load; latency unchanged.
- Undefined: in_data is written unmodified.

Test Plan:
- Params OUT_WIDTH=3, OUT_HEIGHT=2, KERNEL_NUM=2, mem_ready=1. Pulse start, then stream 12 values 100..111 back-to-back. Required response:
  - mem_addr sequence 0,6,1,7,2,8,3,9,4,10,5,11.
  - Matching data 100..111 on consecutive cycles.
  - frame_done pulse exactly one cycle after the write to address 11; busy falls the following cycle.
- Same stream, mem_ready toggling 1,0,0,1 repeating. Required response:
  - No writes lost or duplicated.
  - mem_addr and mem_data stable while mem_ready=0.
  - in_ready=0 whenever a pending write is stalled.
- in_valid=1 with in_data=55 while IDLE. Required response: in_ready=0, mem_we never asserts, and the first address after a later start is 0.
- Reset asserted after the 5th accept with a write pending. Required response:
  - mem_we=0 and busy=0 immediately, without waiting for a clock edge.
  - After release and a new start, addresses restart at 0.
- start pulsed again at accept 3 of a frame. Required response: ignored, and the address sequence continues 7,2,8,...
- With FMAP_RELU_EN, input 0xFFFFFFF6 (-10) then 0x00000007. Required response: mem_data 0x00000000 then 0x00000007. Without the macro: 0xFFFFFFF6 then 0x00000007.
